syn_weight_loader: RTL
======================

// Module: syn_weight_loader
// PURPOSE
// Initiator side of the synapse table port. Accepts a byte stream of initial
// integer weights over a valid/ready handshake and drives the synapse write
// interface, one byte lane per beat. Sits between the host/config path and one
// synapse instance. Optionally reads the table back and checks a sum.
// PARAMETERS
// DEPTH    128  synapse byte entries (iADDR[6:0] range); max bytes per load
// RD_LAT   3    cycles from syn_R_EN beat to valid syn_weight_in[15:8]
// PORTS
// clk            in   1   single clock, posedge
// rst            in   1   async reset, active-low
// start          in   1   1-cycle pulse: begin a table load (ignored unless IDLE)
// s_valid        in   1   weight byte valid
// s_ready        out  1   loader accepts byte this cycle
// s_data         in   8   integer weight byte
// s_last         in   1   final byte of this table (qualified by s_valid&s_ready)
// busy           out  1   high from start acceptance until done pulse
// done           out  1   1-cycle pulse at end of load (and verify)
// err            out  1   verify mismatch, sticky until next start; 0 if no verify
// loaded         out  8   number of bytes written in last/current load
// syn_kill       out  1   clears synapse output/state; driven 1 for one cycle
// syn_iADDR      out  16  synapse byte address; [15:7] always 0
// syn_W_DATA     out  32  byte placed in lane iADDR%4, other lanes 0
// syn_W_EN       out  1   synapse write strobe
// syn_R_EN       out  1   synapse read strobe
// syn_weight_in  in   16  synapse weight_out; [15:8] integer byte
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; s_ready, busy, done, err, syn_kill,
//   syn_W_EN, syn_R_EN = 0; syn_iADDR, syn_W_DATA, loaded = 0; index, sum = 0.
// - Reset mid-load aborts immediately; partial table contents undefined.
// - FSM: IDLE -> KILL -> LOAD -> [VERIFY -> DRAIN] -> DONE -> IDLE.
// - IDLE: start=1 -> KILL; busy<=1, err<=0, loaded<=0, sum<=0.
// - KILL: syn_kill=1 for exactly 1 cycle -> LOAD.
// - LOAD: s_ready=1 while index<DEPTH. On s_valid&s_ready (cycle t), at t+1:
//   syn_W_EN=1, syn_R_EN=0, syn_iADDR=index,
//   syn_W_DATA = s_data << (8*index[1:0]). Then index++, loaded++, sum+=s_data
//   (16-bit, wraps). Back-to-back beats allowed: one write per cycle.
// - syn_W_EN=0 on cycles with no accepted byte; address/data hold last value.
// - Exit LOAD after the beat with s_last=1 or the beat at index DEPTH-1.
//   s_ready drops the cycle after the exit beat; no further bytes consumed.
// - s_last on the first beat loads 1 byte. Bytes past DEPTH are never accepted.
// - Without verify: LOAD -> DONE. DONE: done=1 one cycle, busy<=0 -> IDLE.
// - start while busy: ignored, no state change.
// - s_data changing while s_valid=1, s_ready=0: no effect.
// CONFIGURATION
// - SYN_LOADER_VERIFY_EN defined: LOAD -> VERIFY. VERIFY issues `loaded` read
//   beats, one per cycle: syn_R_EN=1, syn_W_EN=0, syn_iADDR=0..loaded-1.
//   Each returned byte syn_weight_in[15:8] is sampled RD_LAT cycles after its
//   beat and accumulated into rsum (16-bit). DRAIN waits RD_LAT cycles after the
//   last beat. Then err<=(rsum!=sum), -> DONE.
// - Not defined: no VERIFY/DRAIN states, syn_R_EN tied 0, err tied 0.
// TESTING
// - Reset: rst low mid-LOAD -> all outputs 0 same cycle; state IDLE after release.
// - Full load: start, 128 bytes b=i with no gaps -> 128 writes, iADDR 0..127.
//   Lane check: iADDR=5 gives W_DATA=32'h0000_0500. loaded=128, done 1 cycle later.
//   s_ready low after byte 127.
// - Early last: 3 bytes 0xA1,0xB2,0xC3 (last on C3) -> writes at iADDR 0,1,2.
//   Lanes 0,1,2 used; loaded=3; s_ready=0 afterwards.
// - Backpressure/gaps: s_valid toggling 1010..., 4 bytes -> exactly 4 W_EN
//   pulses, none on idle cycles. start asserted mid-load is ignored.
// - Kill sequencing: start -> syn_kill=1 exactly one cycle, first W_EN no
//   earlier than 2 cycles after start.
// - Verify (SYN_LOADER_VERIFY_EN): model returns correct data -> err=0. Model
//   corrupts entry 7 by +1 -> err=1 at done, cleared by the next start.

Source files
------------

// File: rtl/syn_weight_loader.sv
// Streams integer weight bytes into one synapse table, one byte lane per write.
// Optional read-back sum check enabled by defining SYN_LOADER_VERIFY_EN.
module syn_weight_loader #(
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  loaded,
  output logic        syn_kill,
  output logic [15:0] syn_iADDR,
  output logic [31:0] syn_W_DATA,
  output logic        syn_W_EN,
  output logic        syn_R_EN,
  input  logic [15:0] syn_weight_in
);

  // state  | meaning
  // IDLE   | waiting for start
  // KILL   | one-cycle synapse clear
  // LOAD   | accepting bytes, one write per accepted byte
  // VERIFY | issuing read beats 0..loaded-1
  // DRAIN  | waiting for the last read byte to return
  // DONE   | one-cycle done pulse, back to IDLE
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_KILL   = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
`ifdef SYN_LOADER_VERIFY_EN
  localparam logic [2:0] ST_VERIFY = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
`endif
  localparam logic [7:0] LAST_IDX  = 8'(DEPTH - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  loaded_q, loaded_d;
  logic [15:0] sum_q, sum_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        kill_q, kill_d;
  logic        w_en_q, w_en_d;
  logic [6:0]  iaddr_q, iaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        accept;
  logic        unused_in;

`ifdef SYN_LOADER_VERIFY_EN
  logic              r_en_q, r_en_d;
  logic              err_q, err_d;
  logic [15:0]       rsum_q, rsum_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [3:0]        drain_q, drain_d;
`endif

  assign s_ready = (state_q == ST_LOAD) && (index_q < 8'(DEPTH));
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    loaded_d = loaded_q;
    sum_d    = sum_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    kill_d   = 1'b0;
    w_en_d   = 1'b0;
    iaddr_d  = iaddr_q;
    wdata_d  = wdata_q;
`ifdef SYN_LOADER_VERIFY_EN
    r_en_d    = 1'b0;
    err_d     = err_q;
    drain_d   = drain_q;
    rd_pipe_d = (rd_pipe_q << 1) | {{(RD_LAT-1){1'b0}}, r_en_q};
    rsum_d    = rsum_q;
    // Oldest pipe bit marks the cycle its read byte is valid on the bus.
    if (rd_pipe_q[RD_LAT-1]) rsum_d = rsum_q + {8'h00, syn_weight_in[15:8]};
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_KILL;
          busy_d   = 1'b1;
          kill_d   = 1'b1;
          loaded_d = '0;
          sum_d    = '0;
          index_d  = '0;
`ifdef SYN_LOADER_VERIFY_EN
          err_d    = 1'b0;
          rsum_d   = '0;
`endif
        end
      end
      ST_KILL: state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          w_en_d   = 1'b1;
          iaddr_d  = index_q[6:0];
          wdata_d  = {24'h0, s_data} << {index_q[1:0], 3'b000};
          index_d  = index_q + 8'd1;
          loaded_d = loaded_q + 8'd1;
          sum_d    = sum_q + {8'h00, s_data};
          if (s_last || index_q == LAST_IDX) begin
`ifdef SYN_LOADER_VERIFY_EN
            state_d = ST_VERIFY;
            index_d = '0;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef SYN_LOADER_VERIFY_EN
      ST_VERIFY: begin
        r_en_d  = 1'b1;
        iaddr_d = index_q[6:0];
        index_d = index_q + 8'd1;
        if (index_q == loaded_q - 8'd1) begin
          state_d = ST_DRAIN;
          drain_d = 4'(RD_LAT);
        end
      end
      ST_DRAIN: begin
        // Terminal count lines up with the final byte's sample edge.
        if (drain_q == 4'd0) begin
          err_d   = (rsum_d != sum_q);
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
`endif
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      loaded_q <= '0;
      sum_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      kill_q   <= 1'b0;
      w_en_q   <= 1'b0;
      iaddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      loaded_q <= loaded_d;
      sum_q    <= sum_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      kill_q   <= kill_d;
      w_en_q   <= w_en_d;
      iaddr_q  <= iaddr_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef SYN_LOADER_VERIFY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_q    <= 1'b0;
      err_q     <= 1'b0;
      rsum_q    <= '0;
      rd_pipe_q <= '0;
      drain_q   <= '0;
    end else begin
      r_en_q    <= r_en_d;
      err_q     <= err_d;
      rsum_q    <= rsum_d;
      rd_pipe_q <= rd_pipe_d;
      drain_q   <= drain_d;
    end
  end

  assign syn_R_EN  = r_en_q;
  assign err       = err_q;
  assign unused_in = ^syn_weight_in[7:0];
`else
  assign syn_R_EN  = 1'b0;
  assign err       = 1'b0;
  assign unused_in = ^{syn_weight_in, sum_q};
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign loaded     = loaded_q;
  assign syn_kill   = kill_q;
  assign syn_iADDR  = {9'h000, iaddr_q};
  assign syn_W_DATA = wdata_q;
  assign syn_W_EN   = w_en_q;

endmodule
